sdram_init_checker: RTL

//  SDRAM-side responder for the power-up initialisation bus: decodes CKE/CS/RAS/CAS/WE/BA/ADDR

---
 rtl/sdram_pkg.sv | 64 ++++++
 rtl/sdram_cmd_decode.sv | 28 ++
 rtl/sdram_init_checker.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM bus definitions: command decode, error codes, checker states.
// Mode-word field positions and command encodings are reused by the init FSM.
package sdram_pkg;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_DESEL,
    CMD_PALL,
    CMD_REF,
    CMD_MRS,
    CMD_ILLEGAL
  } cmd_t;

  typedef enum logic [2:0] {
    ERR_NONE   = 3'd0,
    ERR_PWRUP  = 3'd1,
    ERR_ORDER  = 3'd2,
    ERR_TIMING = 3'd3,
    ERR_REF    = 3'd4,
    ERR_MODE   = 3'd5,
    ERR_CKE    = 3'd6
  } err_t;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_REF,
    S_MRSW,
    S_READY,
    S_ERROR
  } state_t;

  localparam logic [3:0] ENC_NOP  = 4'b0111;
  localparam logic [3:0] ENC_PALL = 4'b0010;
  localparam logic [3:0] ENC_REF  = 4'b0001;
  localparam logic [3:0] ENC_MRS  = 4'b0000;

  localparam int MODE_BL_LO  = 0;
  localparam int MODE_BT     = 3;
  localparam int MODE_CAS_LO = 4;
  localparam int MODE_WB     = 9;
  localparam int ADDR_A10    = 10;

  function automatic logic [3:0] burst_len(input logic [2:0] f);
    unique case (f)
      3'b000:  burst_len = 4'd1;
      3'b001:  burst_len = 4'd2;
      3'b010:  burst_len = 4'd4;
      3'b011:  burst_len = 4'd8;
      default: burst_len = 4'd0;
    endcase
  endfunction

  function automatic logic mode_bad(input logic [12:0] m);
    logic [2:0] cas;
    logic [2:0] bl;
    cas = m[MODE_CAS_LO+:3];
    bl  = m[MODE_BL_LO+:3];
    mode_bad = (m[12:10] != 3'b000) || (m[8:7] != 2'b00)
            || !((cas == 3'd2) || (cas == 3'd3))
            || (bl inside {3'b100, 3'b101, 3'b110})
            || ((bl == 3'b111) && m[MODE_BT]);
  endfunction

endpackage

// File: rtl/sdram_cmd_decode.sv
// Combinational decode of the SDRAM command strobes.
// Any chip-selected pattern outside the init set is ILLEGAL.
module sdram_cmd_decode
  import sdram_pkg::*;
(
  input  logic cs_n,
  input  logic ras_n,
  input  logic cas_n,
  input  logic we_n,
  output cmd_t cmd
);

  always_comb begin
    cmd = CMD_ILLEGAL;
    if (cs_n) begin
      cmd = CMD_DESEL;
    end else begin
      unique case ({cs_n, ras_n, cas_n, we_n})
        ENC_NOP:  cmd = CMD_NOP;
        ENC_PALL: cmd = CMD_PALL;
        ENC_REF:  cmd = CMD_REF;
        ENC_MRS:  cmd = CMD_MRS;
        default:  cmd = CMD_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/sdram_init_checker.sv
// SDRAM power-up init sequence checker: order, timing and mode word.
// Flags and counts update on the edge that samples the offending command.
module sdram_init_checker
  import sdram_pkg::*;
#(
  parameter int MIN_NOP_CYCLES = 16,
  parameter int MIN_REF_CMDS   = 2,
  parameter int MIN_REF_GAP    = 1,
  parameter int TMRD           = 2
) (
  input  logic        iclk,
  input  logic        ctr_reset,
  input  logic        isample_en,
  input  logic        DRAM_CKE,
  input  logic        DRAM_CS_N,
  input  logic        DRAM_RAS_N,
  input  logic        DRAM_CAS_N,
  input  logic        DRAM_WE_N,
  input  logic [1:0]  DRAM_BA,
  input  logic [12:0] DRAM_ADDR,
  output logic        odone,
  output logic        oerr,
  output logic [2:0]  oerr_code,
  output logic [12:0] omode_reg,
  output logic [2:0]  ocas_lat,
  output logic [3:0]  oburst_len,
  output logic        owr_single,
  output logic [7:0]  oref_count
);

  localparam logic [7:0] NOP_MIN  = 8'(MIN_NOP_CYCLES);
  localparam logic [7:0] REF_MIN  = 8'(MIN_REF_CMDS);
  localparam logic [7:0] GAP_MIN  = 8'(MIN_REF_GAP);
  localparam logic [7:0] MRD_LAST = 8'(TMRD - 1);

  cmd_t       cmd;
  state_t     state;
  err_t       fault;
  logic       idle;
  logic       a10;
  logic [7:0] nop_cnt;
  logic [7:0] gap_cnt;
  logic [7:0] mrd_cnt;
  logic       unused_ba;

  assign unused_ba = ^DRAM_BA;
  assign idle      = (cmd == CMD_NOP) || (cmd == CMD_DESEL);
  assign a10       = DRAM_ADDR[ADDR_A10];

  sdram_cmd_decode u_dec (
    .cs_n  (DRAM_CS_N),
    .ras_n (DRAM_RAS_N),
    .cas_n (DRAM_CAS_N),
    .we_n  (DRAM_WE_N),
    .cmd   (cmd)
  );

  // CKE is judged before the command in every state that checks it.
  always_comb begin
    fault = ERR_NONE;
    unique case (state)
      S_PWRUP: begin
        if (DRAM_CKE && !idle) begin
          if ((cmd == CMD_PALL) && a10) begin
            if (nop_cnt < NOP_MIN) fault = ERR_PWRUP;
          end else begin
            fault = ERR_ORDER;
          end
        end
      end
      S_REF: begin
        if (!DRAM_CKE) begin
          fault = ERR_CKE;
        end else begin
          unique case (cmd)
            CMD_REF: if (gap_cnt < GAP_MIN) fault = ERR_TIMING;
            CMD_PALL: if (!a10) fault = ERR_ORDER;
            CMD_MRS: begin
              if (gap_cnt < GAP_MIN)           fault = ERR_TIMING;
              else if (oref_count < REF_MIN)   fault = ERR_REF;
              else if (mode_bad(DRAM_ADDR))    fault = ERR_MODE;
            end
            CMD_ILLEGAL: fault = ERR_ORDER;
            default: fault = ERR_NONE;
          endcase
        end
      end
      S_MRSW: begin
        if (!DRAM_CKE)  fault = ERR_CKE;
        else if (!idle) fault = ERR_TIMING;
      end
      default: fault = ERR_NONE;
    endcase
  end

  always_ff @(posedge iclk or posedge ctr_reset) begin
    if (ctr_reset) begin
      state      <= S_PWRUP;
      nop_cnt    <= '0;
      gap_cnt    <= '0;
      mrd_cnt    <= '0;
      odone      <= 1'b0;
      oerr       <= 1'b0;
      oerr_code  <= 3'd0;
      omode_reg  <= '0;
      ocas_lat   <= '0;
      oburst_len <= '0;
      owr_single <= 1'b0;
      oref_count <= '0;
    end else if (isample_en) begin
      if (fault != ERR_NONE) begin
        state     <= S_ERROR;
        oerr      <= 1'b1;
        oerr_code <= fault;
        if (fault == ERR_MODE) begin
          omode_reg  <= DRAM_ADDR;
          ocas_lat   <= DRAM_ADDR[MODE_CAS_LO+:3];
          oburst_len <= burst_len(DRAM_ADDR[MODE_BL_LO+:3]);
          owr_single <= DRAM_ADDR[MODE_WB];
        end
      end else begin
        unique case (state)
          S_PWRUP: begin
            if (!DRAM_CKE) begin
              nop_cnt <= '0;
            end else if (idle) begin
              if (nop_cnt != 8'hFF) nop_cnt <= nop_cnt + 8'd1;
            end else begin
              state   <= S_REF;
              gap_cnt <= '0;
            end
          end
          S_REF: begin
            unique case (cmd)
              CMD_REF: begin
                gap_cnt <= '0;
                if (oref_count != 8'hFF) oref_count <= oref_count + 8'd1;
              end
              CMD_PALL: gap_cnt <= '0;
              CMD_MRS: begin
                state      <= S_MRSW;
                mrd_cnt    <= '0;
                omode_reg  <= DRAM_ADDR;
                ocas_lat   <= DRAM_ADDR[MODE_CAS_LO+:3];
                oburst_len <= burst_len(DRAM_ADDR[MODE_BL_LO+:3]);
                owr_single <= DRAM_ADDR[MODE_WB];
              end
              default: if (gap_cnt != 8'hFF) gap_cnt <= gap_cnt + 8'd1;
            endcase
          end
          S_MRSW: begin
            if (mrd_cnt >= MRD_LAST) begin
              state <= S_READY;
              odone <= 1'b1;
            end else begin
              mrd_cnt <= mrd_cnt + 8'd1;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule
